// File: rtl/fwrisc_csr_rmw.sv
// CSR read-modify-write sequencer: reads a CSR and a GPR from a shared register
// file, applies RW/RS/RC, writes the CSR back and then returns the old value to rd.
module fwrisc_csr_rmw #(
    parameter bit ENABLE_RO_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_imm,
    input  logic [5:0]  req_csr,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_uimm,
    output logic [5:0]  ra_raddr,
    output logic [5:0]  rb_raddr,
    input  logic [31:0] ra_rdata,
    input  logic [31:0] rb_rdata,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CALC, S_WCSR, S_WRD, S_DONE
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t      state_q;
    logic        req_ready_q, rd_wen_q, done_q, illegal_q;
    logic [5:0]  ra_raddr_q, rb_raddr_q, rd_waddr_q;
    logic [31:0] rd_wdata_q, old_q;
    logic [1:0]  op_q;
    logic        imm_q;
    logic [5:0]  csr_q;
    logic [4:0]  rs1_q, rd_q, uimm_q;

    logic [31:0] src_d, new_d;
    logic        sel_nz_d, wreq_d, ill_d;

    // Write-required depends on the operand selector, not on the operand value.
    always_comb begin
        src_d    = imm_q ? {27'b0, uimm_q} : ra_rdata;
        sel_nz_d = imm_q ? (uimm_q != 5'd0) : (rs1_q != 5'd0);
        wreq_d   = (op_q == OP_RW) || (((op_q == OP_RS) || (op_q == OP_RC)) && sel_nz_d);
        ill_d    = (op_q == 2'b00) || !csr_q[5] ||
                   (ENABLE_RO_CHECK && (csr_q[5:3] == 3'b100) && wreq_d);
        case (op_q)
            OP_RS:   new_d = rb_rdata | src_d;
            OP_RC:   new_d = rb_rdata & ~src_d;
            default: new_d = src_d;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rd_wen_q    <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ra_raddr_q  <= '0;
            rb_raddr_q  <= '0;
            rd_waddr_q  <= '0;
            rd_wdata_q  <= '0;
            old_q       <= '0;
            op_q        <= '0;
            imm_q       <= 1'b0;
            csr_q       <= '0;
            rs1_q       <= '0;
            rd_q        <= '0;
            uimm_q      <= '0;
        end else begin
            rd_wen_q   <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            ra_raddr_q <= '0;
            rb_raddr_q <= '0;
            rd_waddr_q <= '0;
            rd_wdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        imm_q       <= req_imm;
                        csr_q       <= req_csr;
                        rs1_q       <= req_rs1;
                        rd_q        <= req_rd;
                        uimm_q      <= req_uimm;
                        ra_raddr_q  <= req_imm ? 6'd0 : {1'b0, req_rs1};
                        rb_raddr_q  <= req_csr;
                        req_ready_q <= 1'b0;
                        state_q     <= S_RD;
                    end
                end
                S_RD: state_q <= S_CALC;
                S_CALC: begin
                    old_q <= rb_rdata;
                    if (ill_d) begin
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (wreq_d) begin
                        rd_wen_q   <= 1'b1;
                        rd_waddr_q <= csr_q;
                        rd_wdata_q <= new_d;
                        state_q    <= S_WCSR;
                    end else if (rd_q != 5'd0) begin
                        rd_wen_q   <= 1'b1;
                        rd_waddr_q <= {1'b0, rd_q};
                        rd_wdata_q <= rb_rdata;
                        state_q    <= S_WRD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WCSR: begin
                    if (rd_q != 5'd0) begin
                        rd_wen_q   <= 1'b1;
                        rd_waddr_q <= {1'b0, rd_q};
                        rd_wdata_q <= old_q;
                        state_q    <= S_WRD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WRD: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign ra_raddr  = ra_raddr_q;
    assign rb_raddr  = rb_raddr_q;
    assign rd_waddr  = rd_waddr_q;
    assign rd_wdata  = rd_wdata_q;
    assign rd_wen    = rd_wen_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fwrisc_csr_rmw.sv
// Directed bench for fwrisc_csr_rmw with a behavioural register file and write log.
module tb_fwrisc_csr_rmw;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic        req_imm = 1'b0;
    logic [5:0]  req_csr = '0;
    logic [4:0]  req_rs1 = '0, req_rd = '0, req_uimm = '0;
    logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
    logic [31:0] ra_rdata = '0, rb_rdata = '0, rd_wdata;
    logic        rd_wen, done, illegal;

    logic [31:0] regs [64];
    logic [5:0]  wa_log [$];
    logic [31:0] wd_log [$];
    int          total = 0, bad = 0;
    int          cyc = 0, acc_cnt = 0;
    int          acc_cyc [$];

    fwrisc_csr_rmw #(.ENABLE_RO_CHECK(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_imm(req_imm), .req_csr(req_csr), .req_rs1(req_rs1),
        .req_rd(req_rd), .req_uimm(req_uimm), .ra_raddr(ra_raddr), .rb_raddr(rb_raddr),
        .ra_rdata(ra_rdata), .rb_rdata(rb_rdata), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .rd_wen(rd_wen), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Register file: read data one cycle after the address.
    always @(posedge clock) begin
        ra_rdata <= regs[ra_raddr];
        rb_rdata <= regs[rb_raddr];
        cyc = cyc + 1;
        if (req_valid && req_ready && !reset) begin
            acc_cnt = acc_cnt + 1;
            acc_cyc.push_back(cyc);
        end
    end

    always @(negedge clock) begin
        if (rd_wen) begin
            wa_log.push_back(rd_waddr);
            wd_log.push_back(rd_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic imm, input logic [5:0] csr,
                          input logic [4:0] rs1, input logic [4:0] rd, input logic [4:0] uimm,
                          input bit hold, output int n, output logic ill,
                          output logic [5:0] ra_seen, output logic [5:0] rb_seen);
        int w;
        wa_log.delete();
        wd_log.delete();
        @(negedge clock);
        req_op = op; req_imm = imm; req_csr = csr;
        req_rs1 = rs1; req_rd = rd; req_uimm = uimm; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        @(posedge clock);
        #1;
        if (!hold) req_valid = 1'b0;
        ra_seen = ra_raddr;
        rb_seen = rb_raddr;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        ill = illegal;
        if (!done) check_val("done_timeout", 32'(n), 32'd0);
        @(posedge clock);
        #1;
        check_val("done_pulse_width", 32'(done), 32'd0);
    endtask

    task automatic expect_txn(input string tag, input int n, input logic ill,
                              input int exp_n, input logic exp_ill, input int exp_cnt,
                              input logic [5:0] a0, input logic [31:0] d0,
                              input logic [5:0] a1, input logic [31:0] d1);
        int sz;
        sz = wa_log.size();
        $display("txn %s: latency=%0d illegal=%0d writes=%0d", tag, n, ill, sz);
        check_val({tag, ".latency"}, 32'(n), 32'(exp_n));
        check_val({tag, ".illegal"}, 32'(ill), 32'(exp_ill));
        check_val({tag, ".nwrites"}, 32'(sz), 32'(exp_cnt));
        if (exp_cnt >= 1 && sz >= 1) begin
            check_val({tag, ".w0addr"}, 32'(wa_log[0]), 32'(a0));
            check_val({tag, ".w0data"}, wd_log[0], d0);
        end
        if (exp_cnt >= 2 && sz >= 2) begin
            check_val({tag, ".w1addr"}, 32'(wa_log[1]), 32'(a1));
            check_val({tag, ".w1data"}, wd_log[1], d1);
        end
    endtask

    initial begin
        int n, w, a1;
        logic ill;
        logic [5:0] ra_s, rb_s;

        for (int i = 0; i < 64; i++) regs[i] = 32'h0;
        regs[5]    = 32'hDEADBEEF;
        regs[9]    = 32'h00000022;
        regs[10]   = 32'h00000000;
        regs[6'h2B] = 32'h12345678;
        regs[6'h2C] = 32'h00000F00;
        regs[6'h2D] = 32'h000000FF;
        regs[6'h21] = 32'h000000A5;
        regs[6'h2E] = 32'h00000011;
        regs[6'h2F] = 32'h00000077;

        // Reset applied before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_val("rst.req_ready", 32'(req_ready), 32'd1);
        check_val("rst.done", 32'(done), 32'd0);
        check_val("rst.illegal", 32'(illegal), 32'd0);
        check_val("rst.rd_wen", 32'(rd_wen), 32'd0);
        check_val("rst.rd_waddr", 32'(rd_waddr), 32'd0);
        check_val("rst.rd_wdata", rd_wdata, 32'd0);
        check_val("rst.raddrs", {20'd0, ra_raddr, rb_raddr}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        do_req(2'b01, 1'b0, 6'h2B, 5'd5, 5'd7, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        check_val("csrrw.ra_raddr", 32'(ra_s), 32'd5);
        check_val("csrrw.rb_raddr", 32'(rb_s), 32'h2B);
        expect_txn("csrrw", n, ill, 5, 1'b0, 2, 6'h2B, 32'hDEADBEEF, 6'h07, 32'h12345678);

        do_req(2'b10, 1'b0, 6'h2C, 5'd0, 5'd3, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("csrrs_rs1_0", n, ill, 4, 1'b0, 1, 6'h03, 32'h00000F00, 6'h0, 32'h0);

        do_req(2'b11, 1'b1, 6'h2D, 5'd0, 5'd0, 5'd3, 1'b0, n, ill, ra_s, rb_s);
        check_val("csrrci.ra_raddr", 32'(ra_s), 32'd0);
        expect_txn("csrrci", n, ill, 4, 1'b0, 1, 6'h2D, 32'h000000FC, 6'h0, 32'h0);

        do_req(2'b01, 1'b0, 6'h21, 5'd5, 5'd7, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("ro_write", n, ill, 3, 1'b1, 0, 6'h0, 32'h0, 6'h0, 32'h0);

        do_req(2'b10, 1'b0, 6'h21, 5'd0, 5'd8, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("ro_read", n, ill, 4, 1'b0, 1, 6'h08, 32'h000000A5, 6'h0, 32'h0);

        do_req(2'b00, 1'b0, 6'h2B, 5'd5, 5'd7, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("op00", n, ill, 3, 1'b1, 0, 6'h0, 32'h0, 6'h0, 32'h0);

        do_req(2'b01, 1'b0, 6'h05, 5'd5, 5'd7, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("csr_range", n, ill, 3, 1'b1, 0, 6'h0, 32'h0, 6'h0, 32'h0);

        do_req(2'b01, 1'b0, 6'h30, 5'd5, 5'd0, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("rw_rd0", n, ill, 4, 1'b0, 1, 6'h30, 32'hDEADBEEF, 6'h0, 32'h0);

        do_req(2'b01, 1'b0, 6'h2E, 5'd9, 5'd9, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("rd_eq_rs1", n, ill, 5, 1'b0, 2, 6'h2E, 32'h00000022, 6'h09, 32'h00000011);

        // rs1 nonzero but holding zero still forces the CSR write.
        do_req(2'b10, 1'b0, 6'h2F, 5'd10, 5'd0, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("rs_zero_val", n, ill, 4, 1'b0, 1, 6'h2F, 32'h00000077, 6'h0, 32'h0);

        // Reset during the CSR write cycle.
        wa_log.delete();
        wd_log.delete();
        @(negedge clock);
        req_op = 2'b01; req_imm = 1'b0; req_csr = 6'h31; req_rs1 = 5'd5; req_rd = 5'd7;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        w = 0;
        while (!rd_wen && w < 10) begin
            @(posedge clock);
            #1;
            w++;
        end
        check_val("rst_mid.saw_wcsr", 32'(rd_wen), 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst_mid.rd_wen", 32'(rd_wen), 32'd0);
        check_val("rst_mid.req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        $display("txn rst_mid: writes=%0d", wa_log.size());
        check_val("rst_mid.nwrites", 32'(wa_log.size()), 32'd0);

        do_req(2'b01, 1'b0, 6'h2B, 5'd5, 5'd7, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("post_rst", n, ill, 5, 1'b0, 2, 6'h2B, 32'hDEADBEEF, 6'h07, 32'h12345678);

        // Back-to-back with req_valid held high.
        acc_cnt = 0;
        acc_cyc.delete();
        do_req(2'b01, 1'b0, 6'h2B, 5'd5, 5'd7, 5'd0, 1'b1, n, ill, ra_s, rb_s);
        expect_txn("b2b_first", n, ill, 5, 1'b0, 2, 6'h2B, 32'hDEADBEEF, 6'h07, 32'h12345678);
        do_req(2'b10, 1'b0, 6'h2C, 5'd0, 5'd3, 5'd0, 1'b0, n, ill, ra_s, rb_s);
        expect_txn("b2b_second", n, ill, 4, 1'b0, 1, 6'h03, 32'h00000F00, 6'h0, 32'h0);
        check_val("b2b.accepts", 32'(acc_cnt), 32'd2);
        a1 = (acc_cyc.size() >= 2) ? (acc_cyc[1] - acc_cyc[0]) : 0;
        check_val("b2b.accept_gap", 32'(a1), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwrisc_csr_rmw.md
FWRISC_CSR_RMW -- requirements
Module: fwrisc_csr_rmw

Interface
REQ-001 Parameter: ENABLE_RO_CHECK, 1, when 1 a write to a read-only CSR index (addr[5:3]==3'b100) is flagged illegal; when 0 such writes are issued.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CSR instruction request valid.
REQ-005 req_ready  output  1  high only in IDLE.
REQ-006 req_op  input  2  operation: 01 RW, 10 RS (set bits), 11 RC (clear bits); 00 illegal.
REQ-007 req_imm  input  1  1: source operand is zero-extended req_uimm; 0: source operand is GPR req_rs1.
REQ-008 req_csr  input  6  register-file CSR index; valid range 0x20-0x3F.
REQ-009 req_rs1 / req_rd / req_uimm  input  5 each  source GPR, destination GPR, immediate.
REQ-010 ra_raddr, rb_raddr  output  6 each  register-file read addresses.
REQ-011 ra_rdata, rb_rdata  input  32 each  register-file read data, valid one cycle after address is driven.
REQ-012 rd_waddr  output  6; rd_wdata  output  32; rd_wen  output  1  register-file write port.
REQ-013 done  output  1  one-cycle completion pulse; illegal  output  1  qualifies done.

Function
REQ-014 States: IDLE, RD, CALC, WCSR, WRD, DONE; encoding free.
REQ-015 Request accepted when req_valid && req_ready; op, imm, csr, rs1, rd, uimm captured into registers at that edge; next state RD.
REQ-016 RD: ra_raddr = {1'b0, rs1} (0 when imm=1), rb_raddr = csr; next CALC.
REQ-017 CALC: old = rb_rdata; src = imm ? {27'b0, uimm} : ra_rdata; both latched; new = RW: src, RS: old|src, RC: old&~src.
REQ-018 CALC illegal when op==00, csr[5]==0, or (ENABLE_RO_CHECK and csr[5:3]==3'b100 and csr write required); illegal -> DONE with no writes.
REQ-019 CSR write required for RW always; for RS/RC only when src operand selector is nonzero (uimm!=0 or rs1!=0), regardless of ra_rdata value.
REQ-020 CALC -> WCSR if CSR write required, else WRD if rd!=0, else DONE.
REQ-021 WCSR: rd_wen=1, rd_waddr=csr, rd_wdata=new for exactly one cycle; next WRD if rd!=0 else DONE.
REQ-022 WRD: rd_wen=1, rd_waddr={1'b0, rd}, rd_wdata=old for exactly one cycle; next DONE.
REQ-023 DONE: done=1 for one cycle, illegal=1 iff REQ-018 fired; next IDLE.
REQ-024 rd_wen is 0 in every state other than WCSR/WRD; write to index 0 never issued.
REQ-025 Outside RD, ra_raddr and rb_raddr are 0.
REQ-026 Latency accept-edge to done: 5 cycles with both writes, 4 with one, 3 with none or illegal.
REQ-027 CSR write precedes GPR write; old/src latched in CALC, so rd==rs1 returns the pre-instruction CSR value.
REQ-028 req_valid in non-IDLE states is ignored and not captured; back-to-back requests accepted the cycle after DONE.

Reset
REQ-029 reset asserted: state IDLE, req_ready=1, done=0, illegal=0, rd_wen=0, rd_waddr=0, rd_wdata=0, ra_raddr=0, rb_raddr=0, captured registers 0, immediately without a clock edge.
REQ-030 reset mid-operation aborts the sequence; no further write is issued after reset deasserts.

Verification
REQ-031 CSRRW csr=0x2B old 0x12345678, rs1=5 holding 0xDEADBEEF, rd=7 -> write 0x2B<=0xDEADBEEF, then x7<=0x12345678, done 5 cycles after accept, illegal=0.
REQ-032 CSRRS csr=0x2C old 0x00000F00, rs1=0 -> no CSR write, x rd<=0x00000F00, done after 4 cycles; CSRRC uimm=0x3 old 0xFF -> CSR<=0xFC.
REQ-033 CSRRW csr=0x21 (read-only) with ENABLE_RO_CHECK=1 -> no rd_wen pulses, done with illegal=1 after 3 cycles; CSRRS with rs1=0 on 0x21 -> legal, rd written.
REQ-034 req_op=00 or csr=0x05 -> illegal=1, zero writes; rd=0 with CSRRW -> only the CSR write, done after 4 cycles.
REQ-035 reset asserted during WCSR -> rd_wen drops asynchronously, state IDLE, WRD never occurs; new request after reset completes normally.
REQ-036 Two back-to-back requests with req_valid held high -> second accepted the cycle after first done; req_valid during busy produces no extra capture.
